// File: rtl/enc_pkg.sv
// -----------------------------------------------------------------------------
// enc_pkg
// Shared definitions for the quadrature encoder front end:
//   - ENC_Sxx     : encoder state codes, written as {A,B}
//   - dir_e       : direction of the last valid edge (DIR_UP = 1, DIR_DN = 0)
//   - move_e      : classification of one filtered state change
//   - ERR_CNT_W   : width of the saturating illegal-transition counter
//   - enc_next_up : next state in the counting-up Gray sequence
//   - enc_classify: classifies a (previous, current) state pair
// -----------------------------------------------------------------------------
package enc_pkg;

    localparam logic [1:0] ENC_S00 = 2'b00;
    localparam logic [1:0] ENC_S01 = 2'b01;
    localparam logic [1:0] ENC_S11 = 2'b11;
    localparam logic [1:0] ENC_S10 = 2'b10;

    localparam int ERR_CNT_W = 8;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_e;

    typedef enum logic [1:0] {
        MOVE_IDLE    = 2'd0,
        MOVE_UP      = 2'd1,
        MOVE_DN      = 2'd2,
        MOVE_ILLEGAL = 2'd3
    } move_e;

    // Counting up walks 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] enc_next_up(input logic [1:0] s);
        logic [1:0] n;
        case (s)
            ENC_S00: n = ENC_S01;
            ENC_S01: n = ENC_S11;
            ENC_S11: n = ENC_S10;
            default: n = ENC_S00;
        endcase
        return n;
    endfunction

    // A step one place forward in the Gray cycle is up, one place back is
    // down; anything else that changed flipped both bits and is illegal.
    function automatic move_e enc_classify(input logic [1:0] prev_s,
                                           input logic [1:0] cur_s);
        move_e m;
        if (cur_s == prev_s) begin
            m = MOVE_IDLE;
        end else if (cur_s == enc_next_up(prev_s)) begin
            m = MOVE_UP;
        end else if (prev_s == enc_next_up(cur_s)) begin
            m = MOVE_DN;
        end else begin
            m = MOVE_ILLEGAL;
        end
        return m;
    endfunction

endpackage

// File: rtl/enc_glitch_filter.sv
// -----------------------------------------------------------------------------
// enc_glitch_filter
// Synchroniser plus glitch filter for one raw encoder channel.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   raw_i    : raw pad level, asynchronous to clk
//   thresh_i : number of extra stable cycles required before filt_o follows
//   filt_o   : filtered, synchronous level
// The pad is resynchronised by two flops. The filtered level only follows
// the synchronised level after it has differed for thresh_i+1 consecutive
// cycles; any return to the filtered level restarts the count, so a pulse
// shorter than thresh_i+1 cycles is never seen downstream.
// -----------------------------------------------------------------------------
module enc_glitch_filter
    import enc_pkg::*;
#(
    parameter int FILT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              raw_i,
    input  logic [FILT_W-1:0] thresh_i,
    output logic              filt_o
);

    logic              sync1_q;
    logic              sync1_d;
    logic              sync2_q;
    logic              sync2_d;
    logic              filt_q;
    logic              filt_d;
    logic [FILT_W-1:0] cnt_q;
    logic [FILT_W-1:0] cnt_d;

    always_comb begin
        sync1_d = raw_i;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = cnt_q;
        if (sync2_q == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q >= thresh_i) begin
            // '>=' rather than '==' so that lowering the threshold while a
            // count is in progress cannot let the counter run past it and
            // wrap; with a steady threshold the two are identical.
            filt_d = sync2_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + FILT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/quad_enc_decoder.sv
// -----------------------------------------------------------------------------
// quad_enc_decoder
// Quadrature encoder front end: synchronises and filters ENC_A/ENC_B,
// decodes 4x Gray transitions and keeps a wrapping signed position count.
//   wb_clk_i    : clock, rising edge
//   wb_rst_i    : asynchronous active-high reset
//   enc_a/enc_b : raw encoder channels
//   filt_thresh : filter threshold, registered every cycle
//   load        : one-cycle strobe, position <= load_val (wins over an edge)
//   load_val    : value loaded into position
//   err_clr     : clears err and err_cnt (an illegal edge in the same cycle
//                 wins: err = 1, err_cnt = 1)
//   position    : signed two's complement position, wraps modulo 2^COUNT_W
//   step        : one-cycle pulse per valid decoded edge
//   dir         : direction of last valid edge, 1 = up, 0 = down
//   err         : sticky illegal-transition flag
//   err_cnt     : saturating count of illegal transitions
// Latency: raw pad to filtered level is 2 + (filt_thresh + 1) cycles,
// filtered level to step/dir/position/err is 1 cycle.
// After reset the decoder believes the encoder is at 00; if it is really at
// 11 the first filtered change is decoded as illegal. That is deliberate:
// firmware clears err after releasing reset.
// -----------------------------------------------------------------------------
module quad_enc_decoder
    import enc_pkg::*;
#(
    parameter int                COUNT_W      = 32,
    parameter int                FILT_W       = 4,
    parameter logic [FILT_W-1:0] FILT_DEFAULT = 4'd3
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic [FILT_W-1:0]    filt_thresh,
    input  logic                 load,
    input  logic [COUNT_W-1:0]   load_val,
    input  logic                 err_clr,
    output logic [COUNT_W-1:0]   position,
    output logic                 step,
    output logic                 dir,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // -------------------------------------------------------------------------
    // Threshold register shared by both channel filters
    // -------------------------------------------------------------------------
    logic [FILT_W-1:0] thresh_q;
    logic [FILT_W-1:0] thresh_d;

    assign thresh_d = filt_thresh;

    // -------------------------------------------------------------------------
    // Per-channel synchroniser and glitch filter
    // -------------------------------------------------------------------------
    logic [1:0] raw_ab;
    logic [1:0] filt_ab;

    assign raw_ab = {enc_a, enc_b};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            enc_glitch_filter #(
                .FILT_W (FILT_W)
            ) u_filt (
                .clk      (wb_clk_i),
                .rst      (wb_rst_i),
                .raw_i    (raw_ab[gi]),
                .thresh_i (thresh_q),
                .filt_o   (filt_ab[gi])
            );
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Decode and position counter
    // -------------------------------------------------------------------------
    logic [1:0]           prev_q;
    logic [1:0]           prev_d;
    logic [COUNT_W-1:0]   position_q;
    logic [COUNT_W-1:0]   position_d;
    logic                 step_q;
    logic                 step_d;
    dir_e                 dir_q;
    dir_e                 dir_d;
    logic                 err_q;
    logic                 err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;
    move_e                move;

    assign move = enc_classify(prev_q, filt_ab);

    always_comb begin
        prev_d     = filt_ab;
        position_d = position_q;
        step_d     = 1'b0;
        dir_d      = dir_q;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;

        case (move)
            MOVE_UP: begin
                step_d     = 1'b1;
                dir_d      = DIR_UP;
                position_d = position_q + COUNT_W'(1);
            end
            MOVE_DN: begin
                step_d     = 1'b1;
                dir_d      = DIR_DN;
                position_d = position_q - COUNT_W'(1);
            end
            default: begin
            end
        endcase

        // A load overrides whatever the edge did to position; step and dir
        // still report the edge.
        if (load) begin
            position_d = load_val;
        end

        if (move == MOVE_ILLEGAL) begin
            err_d = 1'b1;
            if (err_clr) begin
                // Clear and a new illegal edge together: the new one counts.
                err_cnt_d = ERR_CNT_W'(1);
            end else if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
        end else if (err_clr) begin
            err_d     = 1'b0;
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            thresh_q   <= FILT_DEFAULT;
            prev_q     <= ENC_S00;
            position_q <= '0;
            step_q     <= 1'b0;
            dir_q      <= DIR_UP;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            thresh_q   <= thresh_d;
            prev_q     <= prev_d;
            position_q <= position_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign position = position_q;
    assign step     = step_q;
    assign dir      = dir_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;

endmodule
